pattern_sequencer: RTL and testbench
====================================

Name: pattern_sequencer

Overview:
Parametrised, runtime-programmable output pattern sequencer. It generalises the fixed 6-step, 8-bit output stepper in this codebase. A small pattern memory is loaded through a write port. The block steps through entries 0..len at a programmable rate, forwards or backwards, either looping or one-shot. It drives a registered WIDTH-bit output bus for actuator/LED/phase drive at the top level.

Parameters:
WIDTH, 8, output/pattern word width
DEPTH, 8, pattern memory entries (power of 2, >=2)
AW, $clog2(DEPTH), step index/address width (derived; do not override)
DIV_W, 16, prescaler divide field width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
wr_en  in  1  pattern memory write strobe
wr_addr  in  AW  pattern memory write address
wr_data  in  WIDTH  pattern memory write data
len  in  AW  last step index; sequence length = len+1
div  in  DIV_W  step period = div+1 clock cycles
dir  in  1  0 = ascending, 1 = descending
oneshot  in  1  0 = loop forever, 1 = stop after terminal step
start  in  1  single-cycle start/restart request
stop  in  1  single-cycle abort request
out  out  WIDTH  registered pattern output
step  out  AW  current step index
busy  out  1  high while in RUN
done  out  1  one-cycle pulse on one-shot completion

Behaviour:
- All state updates on the rising clk edge. reset low at an edge forces:
  - all memory entries = 0
  - out = 0, step = 0, busy = 0, done = 0, prescaler = 0
  - FSM = IDLE
  - reset overrides every other input, including mid-run.
- Memory write: wr_en high writes mem[wr_addr] <= wr_data. Writes are legal in any state.
- Memory read-during-write to the same address returns the old data.
- FSM states: IDLE and RUN.
- IDLE:
  - out and step hold their last values; busy = 0.
  - start=1 (and stop=0) -> RUN next edge.
  - On that edge: step <= S0, out <= mem[S0], prescaler <= 0.
  - S0 = 0 if dir=0; S0 = len if dir=1.
- RUN:
  - busy = 1.
  - Prescaler counts 0..div. tick = (prescaler == div); on tick, prescaler <= 0.
  - div=0 means a tick every cycle, so each pattern is held exactly div+1 cycles.
  - On tick with dir=0: next = (step >= len) ? 0 : step+1.
  - On tick with dir=1: next = (step == 0 || step > len) ? len : step-1.
  - step <= next and out <= mem[next] on the same edge; out never lags step.
  - Terminal step is len when dir=0, and 0 when dir=1.
  - If oneshot=1 and tick occurs on the terminal step: FSM -> IDLE, done = 1 for exactly one cycle, busy = 0. step and out hold the terminal values (no advance).
  - stop=1 -> IDLE next edge; out and step hold; no done pulse.
  - start=1 while in RUN restarts: step <= S0, out <= mem[S0], prescaler <= 0.
  - start and stop in the same cycle: stop wins.
- Mid-run changes:
  - len, dir, div and oneshot are sampled live.
  - Reducing len below step causes a wrap at the next tick, per the rules above.
  - Reducing div below the prescaler value causes a tick on the next cycle; compare as prescaler >= div.
  - A write to the currently displayed address does not change out until that step is loaded again.
- done is registered: it is high in the cycle after the completing edge and low otherwise.
- No combinational path from any input to out, step, busy or done.

Test Plan:
- Legacy pattern, up/loop/div=0:
  - Load 0x90,0x18,0x48,0x60,0x24,0x84 at addresses 0..5; len=5, dir=0, oneshot=0; pulse start.
  - Required: out = 90,18,48,60,24,84,90,… with one value per cycle; step 0..5 wrapping; busy=1.
- Prescale, div=3:
  - Same load and settings as above, with div=3.
  - Required: each value held exactly 4 cycles; step changes every 4th edge.
- Descending one-shot, dir=1, oneshot=1:
  - Required: out = 84,24,60,48,18,90.
  - After 90 has been held div+1 cycles: done pulses for one cycle, busy=0, out stays 0x90, step=0.
- Mid-run control:
  - stop at step 3 -> IDLE; out holds 0x60; no done.
  - start and stop in the same cycle -> remains IDLE.
  - start during RUN at step 4 -> step=0, out=0x90 on the next edge.
- Reset and boundaries:
  - reset low mid-run -> out=0, step=0, busy=0, and mem reads 0 after the next start.
  - len shrunk from 5 to 2 while step=4 -> next tick step=0.
  - Write to the current address mid-run -> new value appears only on the next visit.

Source files
------------

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: runtime-programmable output pattern stepper.
// A DEPTH-entry pattern memory is loaded through a write port. While running,
// the block walks entries 0..len (ascending) or len..0 (descending), holding
// each entry for div+1 cycles, either looping or stopping after one pass.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-low reset (clears memory and all state)
//   wr_en    pattern memory write strobe; wr_addr / wr_data give the entry
//   len      last step index (sequence length = len+1), sampled live
//   div      step period = div+1 cycles, sampled live
//   dir      0 ascending, 1 descending
//   oneshot  0 loop forever, 1 stop after the terminal step
//   start    start/restart request (one cycle)
//   stop     abort request (one cycle), wins over start
//   out      registered pattern output
//   step     registered current step index
//   busy     registered, high while running
//   done     registered one-cycle pulse on one-shot completion
module pattern_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    len,
  input  logic [DIV_W-1:0] div,
  input  logic             dir,
  input  logic             oneshot,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] out,
  output logic [AW-1:0]    step,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] presc_nxt;
  logic [AW-1:0]    step_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             done_nxt;
  logic [AW-1:0]    s0;
  logic [AW-1:0]    adv;
  logic             tick;
  logic             term;

  // Start index, tick, terminal detect and the next step in the current direction.
  // The >= compare makes a live reduction of div tick on the next cycle.
  always_comb begin
    s0   = dir ? len : '0;
    tick = (presc >= div);
    term = dir ? (step == '0) : (step == len);
    if (!dir) begin
      adv = (step >= len) ? '0 : step + AW'(1);
    end else begin
      adv = ((step == '0) || (step > len)) ? len : step - AW'(1);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (!start && tick && oneshot && term) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs and prescaler.
  // Memory reads here see pre-edge contents, so a same-cycle write returns old data.
  always_comb begin
    step_nxt  = step;
    out_nxt   = out;
    presc_nxt = presc;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          step_nxt  = s0;
          out_nxt   = mem[s0];
          presc_nxt = '0;
        end
      end
      RUN: begin
        if (stop) begin
          // abort: hold step and out
        end else if (start) begin
          step_nxt  = s0;
          out_nxt   = mem[s0];
          presc_nxt = '0;
        end else if (tick) begin
          if (oneshot && term) begin
            done_nxt = 1'b1;
          end else begin
            step_nxt  = adv;
            out_nxt   = mem[adv];
            presc_nxt = '0;
          end
        end else begin
          presc_nxt = presc + DIV_W'(1);
        end
      end
      default: begin
        step_nxt = step;
      end
    endcase
  end

  // Registered outputs, prescaler and pattern memory
  always_ff @(posedge clk) begin
    if (!reset) begin
      out   <= '0;
      step  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      presc <= '0;
      mem   <= '{default: '0};
    end else begin
      out   <= out_nxt;
      step  <= step_nxt;
      busy  <= (state_nxt == RUN);
      done  <= done_nxt;
      presc <= presc_nxt;
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Testbench for pattern_sequencer: the driver pushes the expected post-edge
// outputs into a queue, and a monitor on the falling edge pops and compares.
module tb_pattern_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [2:0]  len;
  logic [15:0] div;
  logic        dir;
  logic        oneshot;
  logic        start;
  logic        stop;
  logic [7:0]  out;
  logic [2:0]  step;
  logic        busy;
  logic        done;

  typedef struct {
    logic [7:0] o;
    logic [2:0] s;
    logic       b;
    logic       d;
    string      nm;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] pat [0:5];

  pattern_sequencer #(
    .WIDTH(8),
    .DEPTH(8),
    .DIV_W(16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .len     (len),
    .div     (div),
    .dir     (dir),
    .oneshot (oneshot),
    .start   (start),
    .stop    (stop),
    .out     (out),
    .step    (step),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Wait for the next active edge, then queue what the outputs must show after it.
  task automatic chk(input logic [7:0] eo, input logic [2:0] es,
                     input logic eb, input logic ed, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    e.o  = eo;
    e.s  = es;
    e.b  = eb;
    e.d  = ed;
    e.nm = nm;
    sb.push_back(e);
  endtask

  // Monitor: compare on the falling edge whenever an expectation is pending.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (out !== mon_e.o || step !== mon_e.s || busy !== mon_e.b || done !== mon_e.d) begin
        errors++;
        $display("FAIL %s @%0t: got out=%h step=%0d busy=%b done=%b, want out=%h step=%0d busy=%b done=%b",
                 mon_e.nm, $time, out, step, busy, done, mon_e.o, mon_e.s, mon_e.b, mon_e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int idx;
    pat[0] = 8'h90; pat[1] = 8'h18; pat[2] = 8'h48;
    pat[3] = 8'h60; pat[4] = 8'h24; pat[5] = 8'h84;
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    len = 3'd5; div = 16'd0; dir = 1'b0; oneshot = 1'b0;
    start = 1'b0; stop = 1'b0;

    chk(8'h00, 3'd0, 1'b0, 1'b0, "reset");
    chk(8'h00, 3'd0, 1'b0, 1'b0, "reset2");
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = pat[i];
      chk(8'h00, 3'd0, 1'b0, 1'b0, "load_idle");
    end
    wr_en = 1'b0;

    // Ascending loop, one value per cycle
    start = 1'b1;
    chk(8'h90, 3'd0, 1'b1, 1'b0, "up_start");
    start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      idx = k % 6;
      chk(pat[idx], 3'(idx), 1'b1, 1'b0, "up_loop");
    end
    stop = 1'b1;
    chk(8'h18, 3'd1, 1'b0, 1'b0, "up_stop");
    stop = 1'b0;

    // Prescaler div=3: each entry held four cycles
    div = 16'd3;
    start = 1'b1;
    chk(8'h90, 3'd0, 1'b1, 1'b0, "div3_start");
    start = 1'b0;
    for (int c = 1; c <= 27; c++) begin
      idx = (c / 4) % 6;
      chk(pat[idx], 3'(idx), 1'b1, 1'b0, "div3_hold");
    end
    stop = 1'b1;
    chk(8'h90, 3'd0, 1'b0, 1'b0, "div3_stop");
    stop = 1'b0;
    div = 16'd0;

    // Descending one-shot
    dir = 1'b1; oneshot = 1'b1;
    start = 1'b1;
    chk(8'h84, 3'd5, 1'b1, 1'b0, "dn_start");
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      idx = 5 - k;
      chk(pat[idx], 3'(idx), 1'b1, 1'b0, "dn_step");
    end
    chk(8'h90, 3'd0, 1'b0, 1'b1, "dn_done");
    chk(8'h90, 3'd0, 1'b0, 1'b0, "dn_idle");
    chk(8'h90, 3'd0, 1'b0, 1'b0, "dn_idle2");
    dir = 1'b0; oneshot = 1'b0;

    // Mid-run control: stop, start+stop, restart
    start = 1'b1;
    chk(8'h90, 3'd0, 1'b1, 1'b0, "mid_start");
    start = 1'b0;
    for (int k = 1; k <= 3; k++) chk(pat[k], 3'(k), 1'b1, 1'b0, "mid_run");
    stop = 1'b1;
    chk(8'h60, 3'd3, 1'b0, 1'b0, "stop_hold");
    stop = 1'b0;
    chk(8'h60, 3'd3, 1'b0, 1'b0, "idle_hold");
    start = 1'b1; stop = 1'b1;
    chk(8'h60, 3'd3, 1'b0, 1'b0, "start_stop");
    stop = 1'b0;
    chk(8'h90, 3'd0, 1'b1, 1'b0, "restart_idle");
    start = 1'b0;
    for (int k = 1; k <= 4; k++) chk(pat[k], 3'(k), 1'b1, 1'b0, "to_step4");
    start = 1'b1;
    chk(8'h90, 3'd0, 1'b1, 1'b0, "restart_run");
    start = 1'b0;

    // len shrink while at step 4, then read-during-write and revisit
    for (int k = 1; k <= 4; k++) chk(pat[k], 3'(k), 1'b1, 1'b0, "pre_shrink");
    len = 3'd2;
    chk(8'h90, 3'd0, 1'b1, 1'b0, "shrink_wrap");
    chk(8'h18, 3'd1, 1'b1, 1'b0, "len2_s1");
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hAA;
    chk(8'h48, 3'd2, 1'b1, 1'b0, "rdw_old");
    wr_en = 1'b0;
    chk(8'h90, 3'd0, 1'b1, 1'b0, "len2_s0");
    chk(8'h18, 3'd1, 1'b1, 1'b0, "len2_s1b");
    chk(8'hAA, 3'd2, 1'b1, 1'b0, "new_on_revisit");
    chk(8'h90, 3'd0, 1'b1, 1'b0, "len2_s0b");

    // Live div reduction below the prescaler value ticks next cycle
    div = 16'd3;
    chk(8'h90, 3'd0, 1'b1, 1'b0, "div_a");
    chk(8'h90, 3'd0, 1'b1, 1'b0, "div_b");
    div = 16'd1;
    chk(8'h18, 3'd1, 1'b1, 1'b0, "div_reduce");
    chk(8'h18, 3'd1, 1'b1, 1'b0, "div1_hold");
    chk(8'hAA, 3'd2, 1'b1, 1'b0, "div1_adv");
    div = 16'd0;

    // Reset mid-run clears state and memory
    reset = 1'b0;
    chk(8'h00, 3'd0, 1'b0, 1'b0, "reset_mid");
    reset = 1'b1;
    start = 1'b1;
    chk(8'h00, 3'd0, 1'b1, 1'b0, "mem_cleared0");
    start = 1'b0;
    chk(8'h00, 3'd1, 1'b1, 1'b0, "mem_cleared1");
    stop = 1'b1;
    chk(8'h00, 3'd1, 1'b0, 1'b0, "end_stop");
    stop = 1'b0;

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
